// File: rtl/grid_game_ctrl_pkg.sv
// Shared encodings for the grid game controller: game states, cell contents
// and the four scan directions used during CHECK.
package grid_game_ctrl_pkg;

  typedef enum logic [2:0] {
    START  = 3'd0,
    X_TURN = 3'd1,
    O_TURN = 3'd2,
    TIE    = 3'd3,
    X_WINS = 3'd4,
    O_WINS = 3'd5,
    CHECK  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    CELL_O = 2'b01,
    CELL_X = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_t;

endpackage

// File: rtl/grid_line_counter.sv
// Combinational run length through one cell along one direction: the cell
// itself plus contiguous same-symbol neighbours on both sides.
module grid_line_counter
  import grid_game_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_N = 3,
  localparam int unsigned CW = $clog2(BOARD_N)
) (
  input  logic [2*BOARD_N*BOARD_N-1:0] board,
  input  dir_t                         dir,
  input  logic [CW-1:0]                row,
  input  logic [CW-1:0]                col,
  input  cell_t                        sym,
  output logic [3:0]                   count
);

  logic [1:0]  grid [BOARD_N][BOARD_N];
  logic [31:0] dr, dc, rr, cc;
  logic        fwdRun, bwdRun;

  always_comb begin
    for (int unsigned r = 0; r < BOARD_N; r++)
      for (int unsigned c = 0; c < BOARD_N; c++)
        grid[r][c] = board[2*(r*BOARD_N+c) +: 2];
  end

  // Steps are 32-bit two's complement; stepping off the board wraps to a huge
  // unsigned value, so a single "< BOARD_N" test covers both edges.
  always_comb begin
    case (dir)
      DIR_H:   begin dr = 32'd0; dc = 32'd1; end
      DIR_V:   begin dr = 32'd1; dc = 32'd0; end
      DIR_D:   begin dr = 32'd1; dc = 32'd1; end
      default: begin dr = 32'd1; dc = '1;    end
    endcase
    count  = 4'd1;
    fwdRun = 1'b1;
    bwdRun = 1'b1;
    rr     = '0;
    cc     = '0;
    for (int unsigned i = 1; i < BOARD_N; i++) begin
      rr = 32'(row) + i*dr;
      cc = 32'(col) + i*dc;
      if (fwdRun && rr < BOARD_N && cc < BOARD_N && grid[CW'(rr)][CW'(cc)] == sym)
        count = count + 4'd1;
      else
        fwdRun = 1'b0;
      rr = 32'(row) - i*dr;
      cc = 32'(col) - i*dc;
      if (bwdRun && rr < BOARD_N && cc < BOARD_N && grid[CW'(rr)][CW'(cc)] == sym)
        count = count + 4'd1;
      else
        bwdRun = 1'b0;
    end
  end

endmodule

// File: rtl/grid_game_ctrl.sv
// Two-player N-in-a-row game controller: board register, move FSM with a
// four-cycle win scan, saturating scores and a two-option button menu.
module grid_game_ctrl
  import grid_game_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_N = 3,
  parameter int unsigned WIN_LEN = 3,
  parameter int unsigned SCORE_W = 7,
  localparam int unsigned CW = $clog2(BOARD_N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         move_valid,
  input  logic [CW-1:0]                move_row,
  input  logic [CW-1:0]                move_col,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_action,
  output logic [2*BOARD_N*BOARD_N-1:0] board,
  output logic [2:0]                   state,
  output logic [SCORE_W-1:0]           x_score,
  output logic [SCORE_W-1:0]           o_score,
  output logic                         selected_option,
  output logic                         move_ack,
  output logic                         move_err
);

  localparam int unsigned CELLS = BOARD_N*BOARD_N;
  localparam int unsigned MC_W  = $clog2(CELLS+1);
  localparam logic [MC_W-1:0] FULL = MC_W'(CELLS);

  state_t               stateQ;
  dir_t                 dirQ;
  cell_t                gridQ [BOARD_N][BOARD_N];
  logic [2*CELLS-1:0]   boardFlat;
  logic [CW-1:0]        lastRow, lastCol;
  cell_t                lastSym;
  logic                 winAcc;
  logic [MC_W-1:0]      moveCnt;
  logic                 firstIsX;
  logic                 leftQ, rightQ, actionQ;
  logic [SCORE_W-1:0]   xScoreQ, oScoreQ;
  logic                 optionQ, ackQ, errQ;

  logic                 leftEdge, rightEdge, actionEdge;
  logic                 inRange, cellFree, moveState, endState;
  logic                 doWrite, doClear, liveMove;
  cell_t                mover;
  logic [3:0]           runLen;
  logic                 winNow;

  always_comb begin
    boardFlat = '0;
    for (int unsigned r = 0; r < BOARD_N; r++)
      for (int unsigned c = 0; c < BOARD_N; c++)
        boardFlat[2*(r*BOARD_N+c) +: 2] = gridQ[r][c];
  end

  always_comb begin
    leftEdge   = btn_left   & ~leftQ;
    rightEdge  = btn_right  & ~rightQ;
    actionEdge = btn_action & ~actionQ;
    inRange    = (32'(move_row) < BOARD_N) && (32'(move_col) < BOARD_N);
    cellFree   = 1'b0;
    if (inRange)
      cellFree = (gridQ[move_row][move_col] == EMPTY);
    moveState  = (stateQ == START) || (stateQ == X_TURN) || (stateQ == O_TURN);
    endState   = (stateQ == TIE) || (stateQ == X_WINS) || (stateQ == O_WINS);
    case (stateQ)
      X_TURN:  mover = CELL_X;
      O_TURN:  mover = CELL_O;
      default: mover = firstIsX ? CELL_X : CELL_O;
    endcase
    // An action edge swallows any move presented in the same cycle.
    liveMove = move_valid && !actionEdge;
    doWrite  = liveMove && moveState && inRange && cellFree;
    doClear  = (actionEdge && !optionQ) || (liveMove && endState);
    winNow   = 32'(runLen) >= WIN_LEN;
  end

  grid_line_counter #(
    .BOARD_N (BOARD_N)
  ) u_counter (
    .board (boardFlat),
    .dir   (dirQ),
    .row   (lastRow),
    .col   (lastCol),
    .sym   (lastSym),
    .count (runLen)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || doClear) begin
      for (int unsigned r = 0; r < BOARD_N; r++)
        for (int unsigned c = 0; c < BOARD_N; c++)
          gridQ[r][c] <= EMPTY;
    end else if (doWrite) begin
      gridQ[move_row][move_col] <= mover;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= START;
      dirQ     <= DIR_H;
      lastRow  <= '0;
      lastCol  <= '0;
      lastSym  <= EMPTY;
      winAcc   <= 1'b0;
      moveCnt  <= '0;
      firstIsX <= 1'b1;
      leftQ    <= 1'b0;
      rightQ   <= 1'b0;
      actionQ  <= 1'b0;
      xScoreQ  <= '0;
      oScoreQ  <= '0;
      optionQ  <= 1'b0;
      ackQ     <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      leftQ   <= btn_left;
      rightQ  <= btn_right;
      actionQ <= btn_action;
      ackQ    <= 1'b0;
      errQ    <= 1'b0;
      if (leftEdge ^ rightEdge)
        optionQ <= ~optionQ;

      if (actionEdge && !optionQ) begin
        stateQ  <= START;
        dirQ    <= DIR_H;
        winAcc  <= 1'b0;
        moveCnt <= '0;
      end else begin
        case (stateQ)
          START, X_TURN, O_TURN: begin
            if (doWrite) begin
              lastRow <= move_row;
              lastCol <= move_col;
              lastSym <= mover;
              moveCnt <= moveCnt + MC_W'(1);
              dirQ    <= DIR_H;
              winAcc  <= 1'b0;
              ackQ    <= 1'b1;
              stateQ  <= CHECK;
            end else if (liveMove) begin
              errQ <= 1'b1;
            end
          end
          CHECK: begin
            if (liveMove)
              errQ <= 1'b1;
            if (dirQ == DIR_A) begin
              if (winAcc || winNow) begin
                if (lastSym == CELL_X) begin
                  stateQ <= X_WINS;
                  if (xScoreQ != '1) xScoreQ <= xScoreQ + SCORE_W'(1);
                end else begin
                  stateQ <= O_WINS;
                  if (oScoreQ != '1) oScoreQ <= oScoreQ + SCORE_W'(1);
                end
              end else if (moveCnt == FULL) begin
                stateQ <= TIE;
              end else begin
                stateQ <= (lastSym == CELL_X) ? O_TURN : X_TURN;
              end
            end else begin
              dirQ   <= dir_t'(dirQ + 2'd1);
              winAcc <= winAcc | winNow;
            end
          end
          TIE, X_WINS, O_WINS: begin
            if (liveMove) begin
              moveCnt  <= '0;
              firstIsX <= ~firstIsX;
              ackQ     <= 1'b1;
              stateQ   <= START;
            end
          end
          default: stateQ <= START;
        endcase
        // Placed last so a score-clear request beats a same-cycle win increment.
        if (actionEdge) begin
          xScoreQ <= '0;
          oScoreQ <= '0;
        end
      end
    end
  end

  assign board           = boardFlat;
  assign state           = stateQ;
  assign x_score         = xScoreQ;
  assign o_score         = oScoreQ;
  assign selected_option = optionQ;
  assign move_ack        = ackQ;
  assign move_err        = errQ;

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Bench for grid_game_ctrl: a 3x3 instance driven from a move table with a
// pulse scoreboard, and a 5x5/WIN_LEN=4 instance for the anti-diagonal case.
module tb_grid_game_ctrl;
  import grid_game_ctrl_pkg::*;

  localparam logic [1:0] OP_PLACE   = 2'd0;
  localparam logic [1:0] OP_REJECT  = 2'd1;
  localparam logic [1:0] OP_RESTART = 2'd2;
  localparam logic [1:0] SX = 2'b10;
  localparam logic [1:0] SO = 2'b01;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] op;
    logic [1:0] sym;
    logic [2:0] st;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mv3, bl3, br3, ba3;
  logic [1:0]  row3, col3;
  logic [17:0] board3;
  logic [2:0]  st3;
  logic [6:0]  xs3, os3;
  logic        opt3, ack3, err3;

  logic        mv5;
  logic [2:0]  row5, col5;
  logic [49:0] board5;
  logic [2:0]  st5;
  logic [6:0]  xs5, os5;
  logic        opt5, ack5, err5;
  logic        zero = 1'b0;

  grid_game_ctrl #(.BOARD_N(3), .WIN_LEN(3), .SCORE_W(7)) dut3 (
    .clk(clk), .rst_n(rst_n), .move_valid(mv3), .move_row(row3), .move_col(col3),
    .btn_left(bl3), .btn_right(br3), .btn_action(ba3), .board(board3), .state(st3),
    .x_score(xs3), .o_score(os3), .selected_option(opt3), .move_ack(ack3), .move_err(err3)
  );

  grid_game_ctrl #(.BOARD_N(5), .WIN_LEN(4), .SCORE_W(7)) dut5 (
    .clk(clk), .rst_n(rst_n), .move_valid(mv5), .move_row(row5), .move_col(col5),
    .btn_left(zero), .btn_right(zero), .btn_action(zero), .board(board5), .state(st5),
    .x_score(xs5), .o_score(os5), .selected_option(opt5), .move_ack(ack5), .move_err(err5)
  );

  int nVec = 0;
  int nMis = 0;
  logic [1:0] expQ [$];
  logic [17:0] model3;
  logic [49:0] model5;
  vec_t tab3 [$];
  vec_t tab5 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int c, input logic [1:0] op,
                              input logic [1:0] sym, input state_t st);
    return '{3'(r), 3'(c), op, sym, 3'(st)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input int r, input int c);
    mv3  = 1'b1;
    row3 = 2'(r);
    col3 = 2'(c);
    tick();
    mv3 = 1'b0;
  endtask

  task automatic placeQuiet3(input int r, input int c);
    expQ.push_back(2'b10);
    drive3(r, c);
    repeat (4) tick();
  endtask

  task automatic pressAction();
    ba3 = 1'b1;
    tick();
    ba3 = 1'b0;
    tick();
  endtask

  // Every ack/err pulse of the 3x3 instance must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (ack3 || err3)) begin
      if (expQ.size() == 0) check("unexpected pulse {ack,err}", {ack3, err3}, 2'b00);
      else check("pulse {ack,err}", {ack3, err3}, expQ.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gr [5] = '{0, 1, 0, 1, 0};
    int unsigned gc [5] = '{0, 0, 1, 1, 2};
    vec_t v;

    tab3.push_back(mk(0, 0, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(0, 0, OP_REJECT,  SX, O_TURN));
    tab3.push_back(mk(1, 0, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(3, 0, OP_REJECT,  SX, X_TURN));
    tab3.push_back(mk(0, 1, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(1, 1, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(0, 2, OP_PLACE,   SX, X_WINS));
    tab3.push_back(mk(0, 0, OP_RESTART, SX, START));
    tab3.push_back(mk(0, 0, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(0, 1, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(0, 2, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(1, 1, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(1, 0, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(1, 2, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(2, 1, OP_PLACE,   SO, X_TURN));
    tab3.push_back(mk(2, 0, OP_PLACE,   SX, O_TURN));
    tab3.push_back(mk(2, 2, OP_PLACE,   SO, TIE));
    tab3.push_back(mk(1, 1, OP_RESTART, SX, START));
    tab3.push_back(mk(2, 3, OP_REJECT,  SX, START));
    tab3.push_back(mk(1, 1, OP_PLACE,   SX, O_TURN));

    tab5.push_back(mk(0, 0, OP_PLACE, SX, O_TURN));
    tab5.push_back(mk(0, 4, OP_PLACE, SO, X_TURN));
    tab5.push_back(mk(0, 1, OP_PLACE, SX, O_TURN));
    tab5.push_back(mk(1, 3, OP_PLACE, SO, X_TURN));
    tab5.push_back(mk(1, 0, OP_PLACE, SX, O_TURN));
    tab5.push_back(mk(2, 2, OP_PLACE, SO, X_TURN));
    tab5.push_back(mk(4, 4, OP_PLACE, SX, O_TURN));
    tab5.push_back(mk(3, 1, OP_PLACE, SO, O_WINS));

    rst_n = 1'b0;
    mv3 = 1'b0; row3 = '0; col3 = '0; bl3 = 1'b0; br3 = 1'b0; ba3 = 1'b0;
    mv5 = 1'b0; row5 = '0; col5 = '0;
    model3 = '0;
    model5 = '0;
    repeat (3) tick();
    check("reset board", board3, 18'd0);
    check("reset state", st3, START);
    check("reset scores", {xs3, os3}, 14'd0);
    check("reset option", opt3, 1'b0);
    check("reset pulses", {ack3, err3}, 2'b00);
    rst_n = 1'b1;
    tick();

    // 5x5, four in a row: O anti-diagonal; its 3-long prefix must not win.
    foreach (tab5[k]) begin
      v = tab5[k];
      mv5 = 1'b1; row5 = v.row; col5 = v.col;
      tick();
      mv5 = 1'b0;
      check($sformatf("n5 v%0d ack", k), ack5, 1'b1);
      model5[2*(int'(v.row)*5+int'(v.col)) +: 2] = v.sym;
      repeat (4) tick();
      check($sformatf("n5 v%0d state", k), st5, v.st);
      check($sformatf("n5 v%0d board", k), board5, model5);
    end
    check("n5 scores", {xs5, os5}, {7'd0, 7'd1});

    foreach (tab3[k]) begin
      v = tab3[k];
      expQ.push_back(v.op == OP_REJECT ? 2'b01 : 2'b10);
      drive3(int'(v.row), int'(v.col));
      if (v.op == OP_PLACE) begin
        model3[2*(int'(v.row)*3+int'(v.col)) +: 2] = v.sym;
        repeat (3) tick();
        check($sformatf("v%0d still scanning", k), st3, CHECK);
        tick();
      end else if (v.op == OP_RESTART) begin
        model3 = '0;
      end
      check($sformatf("v%0d state", k), st3, v.st);
      check($sformatf("v%0d board", k), board3, model3);
    end
    check("scores after table", {xs3, os3}, {7'd1, 7'd0});

    // A second move while scanning is rejected and leaves the scan intact.
    expQ.push_back(2'b10);
    drive3(0, 0);
    model3[1:0] = SO;
    expQ.push_back(2'b01);
    drive3(2, 2);
    repeat (3) tick();
    check("move in CHECK state", st3, X_TURN);
    check("move in CHECK board", board3, model3);

    // Held button acts once; option 1 clears scores only.
    br3 = 1'b1;
    repeat (3) tick();
    br3 = 1'b0;
    check("held right option", opt3, 1'b1);
    tick();
    ba3 = 1'b1;
    tick();
    ba3 = 1'b0;
    check("score clear scores", {xs3, os3}, 14'd0);
    check("score clear board", board3, model3);
    check("score clear state", st3, X_TURN);
    bl3 = 1'b1; br3 = 1'b1;
    tick();
    bl3 = 1'b0; br3 = 1'b0;
    check("coincident edges option", opt3, 1'b1);
    tick();
    bl3 = 1'b1;
    tick();
    bl3 = 1'b0;
    check("left edge option", opt3, 1'b0);
    tick();

    // Restart button in CHECK aborts the scan and drops the same-cycle move.
    expQ.push_back(2'b10);
    drive3(2, 2);
    mv3 = 1'b1; row3 = 2'd0; col3 = 2'd1; ba3 = 1'b1;
    tick();
    mv3 = 1'b0; ba3 = 1'b0;
    model3 = '0;
    check("abort state", st3, START);
    check("abort board", board3, model3);
    repeat (5) tick();
    check("abort stays START", st3, START);
    expQ.push_back(2'b10);
    drive3(0, 0);
    model3[1:0] = SX;
    repeat (4) tick();
    check("first player kept state", st3, O_TURN);
    check("first player kept board", board3, model3);

    // Drive x_score to its ceiling, then one more X win.
    for (int unsigned g = 0; g < 128; g++) begin
      pressAction();
      for (int unsigned m = 0; m < 5; m++) placeQuiet3(int'(gr[m]), int'(gc[m]));
      if (g == 126) check("x_score at ceiling", xs3, 7'd127);
    end
    check("x_score saturated", xs3, 7'd127);
    check("saturating win state", st3, X_WINS);
    check("o_score untouched", os3, 7'd0);

    // Reset in the middle of a scan discards the pending result.
    pressAction();
    expQ.push_back(2'b10);
    drive3(1, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-scan reset state", st3, START);
    check("mid-scan reset board", board3, 18'd0);
    check("mid-scan reset scores", {xs3, os3}, 14'd0);
    check("mid-scan reset pulses", {ack3, err3}, 2'b00);
    repeat (5) tick();
    check("post-reset idle state", st3, START);
    check("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
